// File: rtl/fb_hex_writer_if.sv
// rtl/fb_hex_writer_if.sv - font ROM read port and framebuffer write port bundle
interface fb_hex_writer_if;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic        fb_we;
    logic [31:0] fb_waddr;
    logic [7:0]  fb_wdata;

    modport master (
        output rom_addr,
        input  rom_data,
        output fb_we,
        output fb_waddr,
        output fb_wdata
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  fb_we,
        input  fb_waddr,
        input  fb_wdata
    );
endinterface

// File: rtl/fb_hex_writer.sv
// rtl/fb_hex_writer.sv - renders seven-segment digit glyphs from a font ROM into a framebuffer
module fb_hex_writer #(
    parameter int NDIGITS      = 4,
    parameter int GLYPH_ROWS   = 16,
    parameter int ROW_STRIDE   = 40,
    parameter int DIGIT_STRIDE = 2,
    parameter int FB_BASE      = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7*NDIGITS-1:0]   hex_d,
    input  logic                   refresh,
    fb_hex_writer_if.master        bus,
    output logic                   busy,
    output logic                   done
);

    localparam int ROW_W = $clog2(GLYPH_ROWS);
    localparam int DIG_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int IDX_W = ROW_W + DIG_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS * GLYPH_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IDX_W-1:0]       idx;
    logic [7*NDIGITS-1:0]   snap;
    logic                   boot;
    logic                   we_q;
    logic [31:0]            waddr_q;

    logic [ROW_W-1:0]       row;
    logic [DIG_W-1:0]       digit;
    logic [6:0]             code;
    logic                   start;
    logic [31:0]            waddr_nxt;

    // Inner loop walks glyph rows, outer loop walks digits.
    assign row   = idx[ROW_W-1:0];
    assign digit = idx[IDX_W-1:ROW_W];
    assign code  = snap[7*int'(digit) +: 7];

    // A pass is due on new codes, an explicit refresh, or the first cycle out of reset.
    assign start = (hex_d != snap) || refresh || boot;

    // Byte address of the glyph row being fetched this cycle; lands on the bus next cycle.
    assign waddr_nxt = 32'(FB_BASE)
                     + 32'(digit) * 32'(DIGIT_STRIDE)
                     + 32'(row) * 32'(ROW_STRIDE);

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (idx == IDX_LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pass bookkeeping and the one-cycle-delayed write stage that matches ROM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            snap    <= '0;
            boot    <= 1'b1;
            we_q    <= 1'b0;
            waddr_q <= '0;
        end else begin
            we_q <= (state == RUN);
            if (state == IDLE && start) begin
                snap <= hex_d;
                boot <= 1'b0;
                idx  <= '0;
            end else if (state == RUN) begin
                idx <= idx + 1'b1;
            end
            if (state == RUN) begin
                waddr_q <= waddr_nxt;
            end
        end
    end

    // Bus outputs; write data is gated so it reads zero whenever no write is in flight.
    always_comb begin
        bus.rom_addr = 11'd0;
        if (state == RUN) begin
            bus.rom_addr = 11'({code, row});
        end
        bus.fb_we    = we_q;
        bus.fb_waddr = waddr_q;
        bus.fb_wdata = we_q ? bus.rom_data : 8'd0;
        busy         = (state != IDLE);
        done         = (state == DRAIN);
    end

endmodule

// File: tb/tb_fb_hex_writer.sv
// tb/tb_fb_hex_writer.sv - directed self-checking bench for fb_hex_writer
module tb_fb_hex_writer;

    logic        clk;
    logic        rst_n;
    logic [27:0] hex_d;
    logic        refresh;
    logic        busy;
    logic        done;

    fb_hex_writer_if bus_if ();

    fb_hex_writer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .hex_d   (hex_d),
        .refresh (refresh),
        .bus     (bus_if),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [10:0] a);
        return a[7:0] ^ {a[10:8], a[10:6]};
    endfunction

    // Synchronous font ROM model.
    always @(posedge clk) bus_if.rom_data <= rom_byte(bus_if.rom_addr);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic        rec = 1'b0;
    logic [31:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    logic        wr_done[$];
    logic        cyc_we[$];
    logic        cyc_busy[$];
    logic        cyc_done[$];
    logic [10:0] ra_q[$];

    always @(negedge clk) begin
        if (rec) begin
            cyc_we.push_back(bus_if.fb_we);
            cyc_busy.push_back(busy);
            cyc_done.push_back(done);
            if (bus_if.fb_we) begin
                wr_addr.push_back(bus_if.fb_waddr);
                wr_data.push_back(bus_if.fb_wdata);
                wr_done.push_back(done);
            end
            if (busy && !done) ra_q.push_back(bus_if.rom_addr);
        end
    end

    task automatic clear_q();
        wr_addr.delete(); wr_data.delete(); wr_done.delete();
        cyc_we.delete(); cyc_busy.delete(); cyc_done.delete(); ra_q.delete();
    endtask

    task automatic capture(input int n);
        clear_q();
        rec = 1'b1;
        repeat (n) @(posedge clk);
        rec = 1'b0;
        #1;
    endtask

    function automatic logic [27:0] pack(input logic [6:0] d3, input logic [6:0] d2,
                                         input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic verify_pass(input string tag, input logic [27:0] hx, input int w0, input int r0);
        int bad_a = 0;
        int bad_d = 0;
        int bad_r = 0;
        int early = 0;
        logic enough;
        logic [6:0]  c;
        logic [10:0] ea;
        logic [31:0] ew;
        enough = (wr_addr.size() >= w0 + 64) && (ra_q.size() >= r0 + 64);
        check({tag, "_len_ok"}, 32'(enough), 32'd1);
        if (!enough) return;
        for (int j = 0; j < 64; j++) begin
            c  = hx[7*(j/16) +: 7];
            ea = {c, 4'(j % 16)};
            ew = 32'((j / 16) * 2 + (j % 16) * 40);
            if (wr_addr[w0+j] !== ew) bad_a++;
            if (wr_data[w0+j] !== rom_byte(ea)) bad_d++;
            if (ra_q[r0+j] !== ea) bad_r++;
            if (j < 63 && wr_done[w0+j]) early++;
        end
        check({tag, "_bad_waddr"}, 32'(bad_a), 32'd0);
        check({tag, "_bad_wdata"}, 32'(bad_d), 32'd0);
        check({tag, "_bad_rom_addr"}, 32'(bad_r), 32'd0);
        check({tag, "_early_done"}, 32'(early), 32'd0);
        check({tag, "_done_last"}, 32'(wr_done[w0+63]), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            if (!busy) begin ok = 1; break; end
        end
        check({tag, "_idle_reached"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    logic [27:0] code_a;
    logic [27:0] code_b;
    logic [27:0] code_c;

    initial begin
        int cnt;
        int d;
        int i0;
        int p;
        int n1;
        int n0;
        int n2;
        int b;
        int nb;
        int found;

        rst_n   = 1'b0;
        hex_d   = '0;
        refresh = 1'b0;
        code_a  = pack(7'h11, 7'h22, 7'h33, 7'h44);
        code_b  = pack(7'h05, 7'h5A, 7'h60, 7'h01);
        code_c  = pack(7'h7F, 7'h00, 7'h55, 7'h2A);

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fb_we",    32'(bus_if.fb_we), 32'd0);
        check("rst_fb_waddr", bus_if.fb_waddr, 32'd0);
        check("rst_fb_wdata", 32'(bus_if.fb_wdata), 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_done",     32'(done), 32'd0);
        check("rst_rom_addr", 32'(bus_if.rom_addr), 32'd0);

        // Post-reset pass with hex_d = 0.
        @(posedge clk); #1;
        rst_n = 1'b1;
        capture(100);
        check("p1_writes", 32'(wr_addr.size()), 32'd64);
        cnt = 0;
        foreach (cyc_busy[i]) if (cyc_busy[i]) cnt++;
        check("p1_busy_cycles", 32'(cnt), 32'd65);
        cnt = 0;
        foreach (cyc_done[i]) if (cyc_done[i]) cnt++;
        check("p1_done_pulses", 32'(cnt), 32'd1);
        verify_pass("p1", 28'd0, 0, 0);
        if (wr_addr.size() >= 64) begin
            check("p1_w0_addr",  wr_addr[0], 32'd0);
            check("p1_w1_addr",  wr_addr[1], 32'd40);
            check("p1_w16_addr", wr_addr[16], 32'd2);
            check("p1_w63_addr", wr_addr[63], 32'd606);
            check("p1_w63_done", 32'(wr_done[63]), 32'd1);
        end

        // Idle with unchanged codes issues nothing.
        capture(20);
        check("idle_writes", 32'(wr_addr.size()), 32'd0);

        // Digit 0 = 3F.
        hex_d = pack(7'h00, 7'h00, 7'h00, 7'h3F);
        capture(80);
        check("p2_writes", 32'(wr_addr.size()), 32'd64);
        verify_pass("p2", hex_d, 0, 0);
        if (ra_q.size() >= 16) begin
            check("p2_rom_first", 32'(ra_q[0]), 32'd1008);
            check("p2_rom_d0_last", 32'(ra_q[15]), 32'd1023);
        end

        // Codes change at write 10 of a pass.
        hex_d = code_a;
        fork
            capture(170);
            begin
                found = 0;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk); #1;
                    if (wr_addr.size() >= 10) begin found = 1; break; end
                end
                check("p3_reached_w10", 32'(found), 32'd1);
                hex_d = code_b;
            end
        join
        check("p3_writes", 32'(wr_addr.size()), 32'd128);
        verify_pass("p3_old", code_a, 0, 0);
        verify_pass("p3_new", code_b, 64, 64);
        d = -1;
        foreach (cyc_done[i]) if (cyc_done[i] && d < 0) d = i;
        check("p3_done_seen", 32'(d >= 0 && d + 3 < cyc_busy.size()), 32'd1);
        if (d >= 0 && d + 3 < cyc_busy.size()) begin
            check("p3_gap_idle",  32'(cyc_busy[d+1]), 32'd0);
            check("p3_next_run",  32'(cyc_busy[d+2]), 32'd1);
            check("p3_next_we",   32'(cyc_we[d+3]), 32'd1);
        end

        // Refresh held high.
        refresh = 1'b1;
        capture(140);
        refresh = 1'b0;
        i0 = -1;
        foreach (cyc_we[i]) if (cyc_we[i] && i0 < 0) i0 = i;
        check("p4_we_found", 32'(i0 >= 0), 32'd1);
        if (i0 >= 0) begin
            p = i0; n1 = 0; n0 = 0; n2 = 0;
            while (p < cyc_we.size() && cyc_we[p]) begin n1++; p++; end
            while (p < cyc_we.size() && !cyc_we[p]) begin n0++; p++; end
            while (p < cyc_we.size() && cyc_we[p]) begin n2++; p++; end
            check("p4_we_run1", 32'(n1), 32'd64);
            check("p4_we_gap",  32'(n0), 32'd2);
            check("p4_we_run2", 32'(n2), 32'd64);
            b = -1;
            for (int i = i0; i < cyc_busy.size(); i++) if (!cyc_busy[i] && b < 0) b = i;
            nb = 0;
            if (b >= 0) begin
                p = b;
                while (p < cyc_busy.size() && !cyc_busy[p]) begin nb++; p++; end
            end
            check("p4_busy_low_at", 32'(b), 32'(i0 + 64));
            check("p4_busy_low_len", 32'(nb), 32'd1);
        end
        wait_idle("p4");

        // Reset during write 30.
        hex_d = code_c;
        clear_q();
        rec = 1'b1;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (wr_addr.size() >= 30) begin found = 1; break; end
        end
        check("p5_reached_w30", 32'(found), 32'd1);
        check("p5_we_before", 32'(bus_if.fb_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("p5_we_async_low", 32'(bus_if.fb_we), 32'd0);
        check("p5_busy_async_low", 32'(busy), 32'd0);
        clear_q();
        repeat (3) @(posedge clk);
        #1;
        check("p5_no_writes_in_reset", 32'(wr_addr.size()), 32'd0);
        rst_n = 1'b1;
        capture(80);
        check("p5_writes", 32'(wr_addr.size()), 32'd64);
        verify_pass("p5", code_c, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fb_hex_writer.md
FB_HEX_WRITER -- requirements
Module: fb_hex_writer

Interface
REQ-001 Parameter NDIGITS, 4, number of seven-segment digit codes rendered per pass.
REQ-002 Parameter GLYPH_ROWS, 16, font rows per glyph; fixed power of two.
REQ-003 Parameter ROW_STRIDE, 40, framebuffer byte offset between glyph rows.
REQ-004 Parameter DIGIT_STRIDE, 2, framebuffer byte offset between adjacent digits.
REQ-005 Parameter FB_BASE, 0, framebuffer byte address of digit 0, row 0.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 hex_d  in  7*NDIGITS  digit codes; bits [7k+6:7k] are digit k, with digit 0 in the LSBs.
REQ-009 refresh  in  1  level request to force a full pass even when hex_d has not changed.
REQ-010 rom_addr  out  11  font ROM address, code*GLYPH_ROWS+row.
REQ-011 rom_data  in  8  font ROM byte; synchronous ROM, valid one cycle after rom_addr.
REQ-012 fb_we  out  1  framebuffer write strobe.
REQ-013 fb_waddr  out  32  framebuffer write byte address.
REQ-014 fb_wdata  out  8  framebuffer write data.
REQ-015 busy  out  1  high while a pass is in progress.
REQ-016 done  out  1  one-cycle pulse on the final write of a pass.

Function
REQ-017 The FSM SHALL have three states, IDLE, RUN and DRAIN; busy SHALL be high whenever the state is not IDLE.
- IDLE->RUN when any of these holds: hex_d != snap, refresh=1, or the post-reset flag is set.
REQ-018 On the IDLE->RUN edge the block SHALL capture hex_d into snap, clear the post-reset flag and set idx=0.
- snap SHALL hold constant until the pass ends, so a pass renders one consistent code set.
REQ-019 In RUN, idx SHALL count 0..NDIGITS*GLYPH_ROWS-1, one step per cycle, with row=idx mod GLYPH_ROWS (inner loop) and digit=idx/GLYPH_ROWS (outer loop).
REQ-020 In RUN, rom_addr SHALL equal {snap[digit],row[3:0]} combinationally; in IDLE and DRAIN it SHALL be 0.
REQ-021 In the cycle after each RUN cycle, the block SHALL assert:
- fb_we=1;
- fb_wdata=rom_data;
- fb_waddr = FB_BASE + digit*DIGIT_STRIDE + row*ROW_STRIDE, using that RUN cycle's digit and row, computed unsigned in 32 bits, wrap modulo 2^32.
REQ-022 RUN SHALL go to DRAIN after idx reaches NDIGITS*GLYPH_ROWS-1; DRAIN SHALL go to IDLE after one cycle.
REQ-023 fb_we SHALL be high for exactly NDIGITS*GLYPH_ROWS consecutive cycles per pass (64 by default), starting one cycle after RUN entry, and low at all other times.
REQ-024 done SHALL pulse in the DRAIN cycle, coincident with the last write.
- A default pass SHALL keep busy high for 65 cycles.
REQ-025 Changes to hex_d or refresh during RUN or DRAIN SHALL not alter the pass in progress.
- The first IDLE cycle SHALL re-evaluate the start condition, so a change made mid-pass causes the next pass to start one cycle after DRAIN.
REQ-026 With refresh held high, passes SHALL repeat back-to-back with exactly one IDLE cycle between them.
REQ-027 An idle block with hex_d == snap and refresh=0 SHALL issue no writes.

Reset
REQ-028 While rst_n=0 the block SHALL hold:
- state=IDLE, idx=0, snap=0;
- fb_we=0, fb_waddr=0, fb_wdata=0;
- busy=0, done=0, rom_addr=0;
- post-reset flag=1.
REQ-029 Reset asserted mid-pass SHALL deassert fb_we asynchronously and abandon the pass; no further writes from that pass SHALL occur.
REQ-030 After rst_n rises, the first clock edge SHALL start a full pass because of the post-reset flag, even when hex_d=0.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Reset release with hex_d=0 and refresh=0 -> one pass of 64 writes, then idle.
- Write ordering: first write fb_waddr=0; second fb_waddr=40; write 16 fb_waddr=2; last write fb_waddr=606, with done=1 on that same write.
- hex_d digit0 set to 7'h3F after idle -> rom_addr sequence 1008..1023 for digit 0, with fb_wdata equal to the ROM model byte one cycle later.
- hex_d changed at write 10 of a pass -> that pass completes with the old codes; the next pass starts one cycle after DRAIN with the new codes.
- refresh held high -> fb_we pattern of 64 high, 2 low, 64 high; busy low for exactly one cycle between passes.
- rst_n pulsed low during write 30 -> fb_we falls immediately; after release a fresh pass begins at fb_waddr=0.
